// File: rtl/conv2d_asym_operand_streamer.sv
// -----------------------------------------------------------------------------
// conv2d_asym_operand_streamer
//
// Operand sequencer for a 2D convolution with a square input image and an
// asymmetric KH x KW kernel (single channel, dilation 1). On start it walks
// every output pixel in row-major order and, per pixel, every kernel tap
// (kernel row outer, kernel column inner). Each tap becomes one beat on a
// valid/ready stream carrying the pixel, the weight and framing flags.
// Taps that fall into the zero-padding border do not read the image SRAM and
// carry a pixel value of zero.
//
// Pipeline:
//   issue   : counters -> registered SRAM read strobes/addresses
//   in-flight: one cycle while the SRAM produces data
//   land    : SRAM data captured into the output register or a 2-entry skid
// Issue is credit based: a new tap is only issued when the output register,
// the skid and both in-flight stages together still leave room for it, so
// no read result is ever lost under backpressure.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               begin one frame (honoured only when idle)
//   busy, done          frame in progress / one-cycle end-of-frame pulse
//   img_rd_en/addr/data image SRAM read port (data one cycle after enable)
//   wgt_rd_en/addr/data weight SRAM read port (data one cycle after enable)
//   valid_out, ready_in beat handshake toward the conv datapath
//   input_data          pixel value (zero for padded taps)
//   weight_data         weight value
//   first_tap, last_tap beat is tap (0,0) / tap (KH-1,KW-1) of its pixel
//   last_pixel          beat belongs to the final output pixel
// -----------------------------------------------------------------------------
module conv2d_asym_operand_streamer #(
    parameter  int DW     = 32,
    parameter  int IMG    = 8,
    parameter  int KH     = 3,
    parameter  int KW     = 5,
    parameter  int STRIDE = 1,
    parameter  int PAD    = 0,
    localparam int AW     = (IMG * IMG > 1) ? $clog2(IMG * IMG) : 1,
    localparam int WAW    = (KH * KW > 1) ? $clog2(KH * KW) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           img_rd_en,
    output logic [AW-1:0]  img_rd_addr,
    input  logic [DW-1:0]  img_rd_data,
    output logic           wgt_rd_en,
    output logic [WAW-1:0] wgt_rd_addr,
    input  logic [DW-1:0]  wgt_rd_data,
    output logic           valid_out,
    input  logic           ready_in,
    output logic [DW-1:0]  input_data,
    output logic [DW-1:0]  weight_data,
    output logic           first_tap,
    output logic           last_tap,
    output logic           last_pixel
);

    localparam int OH = (IMG + 2 * PAD - KH) / STRIDE + 1;
    localparam int OW = (IMG + 2 * PAD - KW) / STRIDE + 1;
    localparam int CW = $clog2(IMG + 2 * PAD + KH + KW) + 1;
    // beat layout: {first_tap, last_tap, last_pixel, input_data, weight_data}
    localparam int BW = 2 * DW + 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         state_r;
    state_t         state_s;

    logic [CW-1:0]  oy_r;
    logic [CW-1:0]  ox_r;
    logic [CW-1:0]  ky_r;
    logic [CW-1:0]  kx_r;

    int             ih_s;
    int             iw_s;
    logic           inb_s;
    logic [AW-1:0]  img_addr_s;
    logic [WAW-1:0] wgt_addr_s;
    logic           kx_last_s;
    logic           ky_last_s;
    logic           ox_last_s;
    logic           oy_last_s;
    logic           tap_last_s;
    logic           pix_last_s;
    logic           frame_last_s;

    // {first_tap, last_tap, last_pixel, pad} travelling alongside the read
    logic [3:0]     p1_meta_r;
    logic           p1_valid_r;
    logic [3:0]     p2_meta_r;
    logic           p2_valid_r;

    logic [BW-1:0]  out_beat_r;
    logic           valid_out_r;
    logic [BW-1:0]  skid0_r;
    logic [BW-1:0]  skid1_r;
    logic [1:0]     skid_cnt_r;

    logic [BW-1:0]  land_s;
    logic [BW-1:0]  out_beat_s;
    logic           valid_out_s;
    logic [BW-1:0]  skid0_s;
    logic [BW-1:0]  skid1_s;
    logic [1:0]     skid_cnt_s;

    logic           pop_s;
    logic [2:0]     pend_s;
    logic           room_s;
    logic           issue_s;
    logic           final_pop_s;

    assign valid_out   = valid_out_r;
    assign first_tap   = out_beat_r[BW-1];
    assign last_tap    = out_beat_r[BW-2];
    assign last_pixel  = out_beat_r[BW-3];
    assign input_data  = out_beat_r[2*DW-1:DW];
    assign weight_data = out_beat_r[DW-1:0];

    // Tap geometry and SRAM addresses for the current counter position
    always_comb begin
        ih_s         = int'(oy_r) * STRIDE + int'(ky_r) - PAD;
        iw_s         = int'(ox_r) * STRIDE + int'(kx_r) - PAD;
        inb_s        = (ih_s >= 0) && (ih_s < IMG) && (iw_s >= 0) && (iw_s < IMG);
        img_addr_s   = inb_s ? AW'(ih_s * IMG + iw_s) : {AW{1'b0}};
        wgt_addr_s   = WAW'(int'(ky_r) * KW + int'(kx_r));
        kx_last_s    = (kx_r == CW'(KW - 1));
        ky_last_s    = (ky_r == CW'(KH - 1));
        ox_last_s    = (ox_r == CW'(OW - 1));
        oy_last_s    = (oy_r == CW'(OH - 1));
        tap_last_s   = kx_last_s && ky_last_s;
        pix_last_s   = ox_last_s && oy_last_s;
        frame_last_s = tap_last_s && pix_last_s;
    end

    // Credit check: everything stored or in flight, minus the beat leaving now,
    // must stay below the three landing slots (output register + two skid)
    always_comb begin
        pop_s       = valid_out_r && ready_in;
        pend_s      = 3'(valid_out_r) + 3'(skid_cnt_r) + 3'(p1_valid_r)
                      + 3'(p2_valid_r) - 3'(pop_s);
        room_s      = (pend_s < 3'd3);
        issue_s     = room_s && (((state_r == S_IDLE) && start) || (state_r == S_RUN));
        final_pop_s = pop_s && out_beat_r[BW-2] && out_beat_r[BW-3];
    end

    // FSM next-state
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE:  state_s = (start && issue_s) ? (frame_last_s ? S_DRAIN : S_RUN) : S_IDLE;
            S_RUN:   state_s = (issue_s && frame_last_s) ? S_DRAIN : S_RUN;
            S_DRAIN: state_s = final_pop_s ? S_DONE : S_DRAIN;
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // FSM state register and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= state_s;
            busy    <= (state_s != S_IDLE);
            done    <= (state_s == S_DONE);
        end
    end

    // Issue stage: tap counters, SRAM read strobes and the in-flight tag pipe
    always_ff @(posedge clk) begin
        if (rst) begin
            oy_r        <= {CW{1'b0}};
            ox_r        <= {CW{1'b0}};
            ky_r        <= {CW{1'b0}};
            kx_r        <= {CW{1'b0}};
            img_rd_en   <= 1'b0;
            img_rd_addr <= {AW{1'b0}};
            wgt_rd_en   <= 1'b0;
            wgt_rd_addr <= {WAW{1'b0}};
            p1_valid_r  <= 1'b0;
            p1_meta_r   <= 4'd0;
            p2_valid_r  <= 1'b0;
            p2_meta_r   <= 4'd0;
        end else begin
            img_rd_en  <= issue_s && inb_s;
            wgt_rd_en  <= issue_s;
            p1_valid_r <= issue_s;
            p2_valid_r <= p1_valid_r;
            p2_meta_r  <= p1_meta_r;
            if (issue_s) begin
                p1_meta_r   <= {(kx_r == {CW{1'b0}}) && (ky_r == {CW{1'b0}}),
                                tap_last_s, pix_last_s, !inb_s};
                wgt_rd_addr <= wgt_addr_s;
                if (inb_s) begin
                    img_rd_addr <= img_addr_s;
                end else begin
                    img_rd_addr <= img_rd_addr;
                end
                // kx fastest, then ky, ox, oy; all wrap to zero after the frame
                if (!kx_last_s) begin
                    kx_r <= kx_r + CW'(1);
                end else begin
                    kx_r <= {CW{1'b0}};
                    if (!ky_last_s) begin
                        ky_r <= ky_r + CW'(1);
                    end else begin
                        ky_r <= {CW{1'b0}};
                        if (!ox_last_s) begin
                            ox_r <= ox_r + CW'(1);
                        end else begin
                            ox_r <= {CW{1'b0}};
                            oy_r <= oy_last_s ? {CW{1'b0}} : oy_r + CW'(1);
                        end
                    end
                end
            end else begin
                p1_meta_r <= p1_meta_r;
            end
        end
    end

    // Landing logic: output register is the queue head, skid holds the rest in order
    always_comb begin
        land_s      = {p2_meta_r[3:1],
                       p2_meta_r[0] ? {DW{1'b0}} : img_rd_data,
                       wgt_rd_data};
        out_beat_s  = out_beat_r;
        valid_out_s = valid_out_r;
        skid0_s     = skid0_r;
        skid1_s     = skid1_r;
        skid_cnt_s  = skid_cnt_r;
        if (!valid_out_r || pop_s) begin
            if (skid_cnt_r != 2'd0) begin
                out_beat_s  = skid0_r;
                valid_out_s = 1'b1;
                skid0_s     = skid1_r;
                if (p2_valid_r) begin
                    if (skid_cnt_r == 2'd1) begin
                        skid0_s = land_s;
                    end else begin
                        skid1_s = land_s;
                    end
                    skid_cnt_s = skid_cnt_r;
                end else begin
                    skid_cnt_s = skid_cnt_r - 2'd1;
                end
            end else if (p2_valid_r) begin
                out_beat_s  = land_s;
                valid_out_s = 1'b1;
            end else begin
                valid_out_s = 1'b0;
            end
        end else begin
            if (p2_valid_r) begin
                if (skid_cnt_r == 2'd0) begin
                    skid0_s = land_s;
                end else begin
                    skid1_s = land_s;
                end
                skid_cnt_s = skid_cnt_r + 2'd1;
            end else begin
                skid_cnt_s = skid_cnt_r;
            end
        end
    end

    // Output register and skid storage
    always_ff @(posedge clk) begin
        if (rst) begin
            out_beat_r  <= {BW{1'b0}};
            valid_out_r <= 1'b0;
            skid0_r     <= {BW{1'b0}};
            skid1_r     <= {BW{1'b0}};
            skid_cnt_r  <= 2'd0;
        end else begin
            out_beat_r  <= out_beat_s;
            valid_out_r <= valid_out_s;
            skid0_r     <= skid0_s;
            skid1_r     <= skid1_s;
            skid_cnt_r  <= skid_cnt_s;
        end
    end

endmodule

// File: tb/tb_conv2d_asym_operand_streamer.sv
// -----------------------------------------------------------------------------
// Bench for conv2d_asym_operand_streamer. Three instances cover the
// configurations of interest (no padding, padding 1, stride 2); one frame runs
// at a time. Expected beats are generated into a queue before each frame and
// popped as the DUT hands beats over.
// -----------------------------------------------------------------------------
module tb_conv2d_asym_operand_streamer;

    localparam int BW = 67;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic ready = 1'b1;
    int   cyc    = 0;
    int   checks = 0;
    int   fails  = 0;

    logic [BW-1:0] exp_q[$];
    int acc[1:3]      = '{0, 0, 0};
    int done_cnt[1:3] = '{0, 0, 0};
    int frame_acc0, frame_done0, start_cyc;
    int first_cyc, last_cyc, done_cyc, first_addr, last_addr;
    logic saw18 = 1'b0;

    // ---- DUT 1: IMG=4 KH=3 KW=2 STRIDE=1 PAD=0 ----
    logic start1 = 1'b0, busy1, done1, img_rd_en1, wgt_rd_en1, valid1, ft1, lt1, lp1;
    logic [3:0]  img_rd_addr1;
    logic [2:0]  wgt_rd_addr1;
    logic [31:0] img_rd_data1 = 32'd0, wgt_rd_data1 = 32'd0, in1, wt1;
    // ---- DUT 2: IMG=4 KH=3 KW=2 STRIDE=1 PAD=1 ----
    logic start2 = 1'b0, busy2, done2, img_rd_en2, wgt_rd_en2, valid2, ft2, lt2, lp2;
    logic [3:0]  img_rd_addr2;
    logic [2:0]  wgt_rd_addr2;
    logic [31:0] img_rd_data2 = 32'd0, wgt_rd_data2 = 32'd0, in2, wt2;
    // ---- DUT 3: IMG=8 KH=3 KW=5 STRIDE=2 PAD=0 ----
    logic start3 = 1'b0, busy3, done3, img_rd_en3, wgt_rd_en3, valid3, ft3, lt3, lp3;
    logic [5:0]  img_rd_addr3;
    logic [3:0]  wgt_rd_addr3;
    logic [31:0] img_rd_data3 = 32'd0, wgt_rd_data3 = 32'd0, in3, wt3;

    logic [BW-1:0] beat1, beat2, beat3, held1;
    logic hold1 = 1'b0, rst_prev = 1'b1;
    assign beat1 = {ft1, lt1, lp1, in1, wt1};
    assign beat2 = {ft2, lt2, lp2, in2, wt2};
    assign beat3 = {ft3, lt3, lp3, in3, wt3};

    conv2d_asym_operand_streamer #(.DW(32), .IMG(4), .KH(3), .KW(2), .STRIDE(1), .PAD(0)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .img_rd_en(img_rd_en1), .img_rd_addr(img_rd_addr1), .img_rd_data(img_rd_data1),
        .wgt_rd_en(wgt_rd_en1), .wgt_rd_addr(wgt_rd_addr1), .wgt_rd_data(wgt_rd_data1),
        .valid_out(valid1), .ready_in(ready), .input_data(in1), .weight_data(wt1),
        .first_tap(ft1), .last_tap(lt1), .last_pixel(lp1));

    conv2d_asym_operand_streamer #(.DW(32), .IMG(4), .KH(3), .KW(2), .STRIDE(1), .PAD(1)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
        .img_rd_en(img_rd_en2), .img_rd_addr(img_rd_addr2), .img_rd_data(img_rd_data2),
        .wgt_rd_en(wgt_rd_en2), .wgt_rd_addr(wgt_rd_addr2), .wgt_rd_data(wgt_rd_data2),
        .valid_out(valid2), .ready_in(ready), .input_data(in2), .weight_data(wt2),
        .first_tap(ft2), .last_tap(lt2), .last_pixel(lp2));

    conv2d_asym_operand_streamer #(.DW(32), .IMG(8), .KH(3), .KW(5), .STRIDE(2), .PAD(0)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .busy(busy3), .done(done3),
        .img_rd_en(img_rd_en3), .img_rd_addr(img_rd_addr3), .img_rd_data(img_rd_data3),
        .wgt_rd_en(wgt_rd_en3), .wgt_rd_addr(wgt_rd_addr3), .wgt_rd_data(wgt_rd_data3),
        .valid_out(valid3), .ready_in(ready), .input_data(in3), .weight_data(wt3),
        .first_tap(ft3), .last_tap(lt3), .last_pixel(lp3));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] img_val(input int a);
        return 32'hA000_0000 + 32'(a);
    endfunction

    function automatic logic [31:0] wgt_val(input int a);
        return 32'h0B00_0001 + 32'(a);
    endfunction

    // SRAM models with one cycle read latency
    always @(posedge clk) begin
        if (img_rd_en1) img_rd_data1 <= img_val(int'(img_rd_addr1));
        if (wgt_rd_en1) wgt_rd_data1 <= wgt_val(int'(wgt_rd_addr1));
        if (img_rd_en2) img_rd_data2 <= img_val(int'(img_rd_addr2));
        if (wgt_rd_en2) wgt_rd_data2 <= wgt_val(int'(wgt_rd_addr2));
        if (img_rd_en3) img_rd_data3 <= img_val(int'(img_rd_addr3));
        if (wgt_rd_en3) wgt_rd_data3 <= wgt_val(int'(wgt_rd_addr3));
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_beat(input string tag, input logic [BW-1:0] got);
        logic [BW-1:0] e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : ~got;
        checks++;
        assert (got === e) else begin
            fails++;
            $error("FAIL %s_beat: observed %h expected %h", tag, got, e);
        end
    endtask

    // Reference stream: row-major pixels, kernel row outer, kernel column inner
    task automatic build_exp(input int img, input int kh, input int kw, input int s, input int p);
        int oh, ow, ih, iw;
        logic pad;
        logic [31:0] d;
        oh = (img + 2 * p - kh) / s + 1;
        ow = (img + 2 * p - kw) / s + 1;
        for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++)
                for (int ky = 0; ky < kh; ky++)
                    for (int kx = 0; kx < kw; kx++) begin
                        ih  = oy * s + ky - p;
                        iw  = ox * s + kx - p;
                        pad = (ih < 0) || (ih >= img) || (iw < 0) || (iw >= img);
                        d   = pad ? 32'h0 : img_val(ih * img + iw);
                        exp_q.push_back({(ky == 0 && kx == 0), (ky == kh - 1 && kx == kw - 1),
                                         (oy == oh - 1 && ox == ow - 1), d, wgt_val(ky * kw + kx)});
                    end
    endtask

    // Monitor DUT 1: scoreboard, stall stability, timing and address tracking
    always @(negedge clk) begin
        if (hold1 && !rst_prev && !rst) begin
            checks++;
            assert (valid1 === 1'b1 && beat1 === held1) else begin
                fails++;
                $error("FAIL stall_hold: observed valid=%b beat=%h expected valid=1 beat=%h",
                       valid1, beat1, held1);
            end
        end
        if (valid1 && ready) begin
            check_beat("dut1", beat1);
            acc[1]++;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
        end
        hold1    = valid1 && !ready;
        held1    = beat1;
        rst_prev = rst;
        if (done1) begin
            done_cnt[1]++;
            done_cyc = cyc;
        end
        if (img_rd_en1) begin
            if (first_addr < 0) first_addr = int'(img_rd_addr1);
            last_addr = int'(img_rd_addr1);
        end
    end

    // Monitor DUT 2 and DUT 3
    always @(negedge clk) begin
        if (valid2 && ready) begin
            check_beat("dut2", beat2);
            acc[2]++;
        end
        if (done2) done_cnt[2]++;
        if (valid3 && ready) begin
            check_beat("dut3", beat3);
            acc[3]++;
        end
        if (done3) done_cnt[3]++;
        if (img_rd_en3 && img_rd_addr3 == 6'd18) saw18 = 1'b1;
    end

    task automatic kick(input int sel);
        @(posedge clk); #1;
        first_cyc   = -1;
        first_addr  = -1;
        frame_acc0  = acc[sel];
        frame_done0 = done_cnt[sel];
        start1 = (sel == 1);
        start2 = (sel == 2);
        start3 = (sel == 3);
        start_cyc = cyc;
        @(posedge clk); #1;
        start1 = 1'b0;
        start2 = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic finish_frame(input int sel, input int nb, input bit rnd);
        int t;
        t = 0;
        while (done_cnt[sel] == frame_done0 && t < 4000) begin
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            t++;
        end
        ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk($sformatf("done_once_%0d", sel), done_cnt[sel] - frame_done0, 1);
        chk($sformatf("beat_count_%0d", sel), acc[sel] - frame_acc0, nb);
        chk($sformatf("queue_empty_%0d", sel), exp_q.size(), 0);
    endtask

    initial begin
        int t;
        repeat (3) @(posedge clk);
        #1;
        // reset state
        chk("rst_valid", valid1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_img_en", img_rd_en1, 0);
        chk("rst_wgt_en", wgt_rd_en1, 0);
        chk("rst_data", in1, 0);
        chk("rst_flags", {ft1, lt1, lp1}, 0);
        rst = 1'b0;

        // T1: full-throughput frame, timing and address corners
        build_exp(4, 3, 2, 1, 0);
        kick(1);
        finish_frame(1, 36, 1'b0);
        chk("t1_latency", first_cyc - start_cyc, 3);
        chk("t1_contiguous", last_cyc - first_cyc, 35);
        chk("t1_done_delay", done_cyc - last_cyc, 1);
        chk("t1_first_addr", first_addr, 0);
        chk("t1_last_addr", last_addr, 15);

        // T2: padding, first tap is a pad tap with no image read
        build_exp(4, 3, 2, 1, 1);
        kick(2);
        chk("t2_img_en_beat0", img_rd_en2, 0);
        chk("t2_wgt_en_beat0", wgt_rd_en2, 1);
        chk("t2_wgt_addr_beat0", wgt_rd_addr2, 0);
        finish_frame(2, 120, 1'b0);

        // T3: stride 2
        build_exp(8, 3, 5, 2, 0);
        saw18 = 1'b0;
        kick(3);
        finish_frame(3, 90, 1'b0);
        chk("t3_addr18", saw18, 1);

        // T4: random backpressure
        build_exp(4, 3, 2, 1, 0);
        kick(1);
        finish_frame(1, 36, 1'b1);

        // T5: reset mid-frame, then a clean frame
        build_exp(4, 3, 2, 1, 0);
        kick(1);
        t = 0;
        while (acc[1] - frame_acc0 < 10 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk("t5_reached_beat10", (acc[1] - frame_acc0 >= 10) ? 1 : 0, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t5_valid_after_rst", valid1, 0);
        chk("t5_busy_after_rst", busy1, 0);
        rst = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        build_exp(4, 3, 2, 1, 0);
        kick(1);
        finish_frame(1, 36, 1'b0);

        // T6: start pulse during RUN is ignored
        build_exp(4, 3, 2, 1, 0);
        kick(1);
        repeat (5) @(posedge clk);
        #1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        finish_frame(1, 36, 1'b0);
        repeat (60) @(posedge clk);
        #1;
        chk("t6_no_extra_beats", acc[1] - frame_acc0, 36);
        chk("t6_no_extra_done", done_cnt[1] - frame_done0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
